// File: rtl/collide_pkg.sv
// Shared constants for the AABB collision scanner.
// State encodings, default geometry and the per-slot bus slice helper.
package collide_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam int DEF_COORD_W = 9;
    localparam int DEF_NUM_OBJ = 8;

    function automatic int slot_off(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/collide_scan_overlap.sv
// Combinational strict AABB overlap test with widened sums.
// Touching edges and zero-sized boxes never overlap.
module aabb_overlap #(
    parameter int COORD_W = 9
) (
    input  logic [COORD_W-1:0] ax,
    input  logic [COORD_W-1:0] ay,
    input  logic [COORD_W-1:0] aw,
    input  logic [COORD_W-1:0] ah,
    input  logic [COORD_W-1:0] bx,
    input  logic [COORD_W-1:0] by,
    input  logic [COORD_W-1:0] bw,
    input  logic [COORD_W-1:0] bh,
    output logic               overlap
);

    logic [COORD_W:0] axe, aye, bxe, bye;
    logic [COORD_W:0] ax2, ay2, bx2, by2;
    logic             nonzero;

    assign axe = {1'b0, ax};
    assign aye = {1'b0, ay};
    assign bxe = {1'b0, bx};
    assign bye = {1'b0, by};

    // One extra bit keeps right/bottom edges from wrapping.
    assign ax2 = axe + {1'b0, aw};
    assign ay2 = aye + {1'b0, ah};
    assign bx2 = bxe + {1'b0, bw};
    assign by2 = bye + {1'b0, bh};

    assign nonzero = (aw != '0) && (ah != '0) && (bw != '0) && (bh != '0);

    assign overlap = nonzero
                   && (axe < bx2) && (ax2 > bxe)
                   && (aye < by2) && (ay2 > bye);

endmodule

// File: rtl/collide_scan.sv
// Sequential probe-vs-objects AABB scanner, one slot per clock.
// Define COLLIDE_EARLY_EXIT_EN to stop the scan at the first hit.
module collide_scan
    import collide_pkg::*;
#(
    parameter  int COORD_W = DEF_COORD_W,
    parameter  int NUM_OBJ = DEF_NUM_OBJ,
    localparam int IDX_W   = $clog2(NUM_OBJ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       en,
    input  logic [COORD_W-1:0]         px,
    input  logic [COORD_W-1:0]         py,
    input  logic [COORD_W-1:0]         pw,
    input  logic [COORD_W-1:0]         ph,
    input  logic [NUM_OBJ*COORD_W-1:0] obj_x,
    input  logic [NUM_OBJ*COORD_W-1:0] obj_y,
    input  logic [NUM_OBJ*COORD_W-1:0] obj_w,
    input  logic [NUM_OBJ*COORD_W-1:0] obj_h,
    input  logic [NUM_OBJ-1:0]         obj_valid,
    output logic                       busy,
    output logic                       done,
    output logic                       hit_any,
    output logic [NUM_OBJ-1:0]         hit_mask,
    output logic [IDX_W-1:0]           hit_idx
);

`ifdef COLLIDE_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic [1:0]               state;
    logic [IDX_W-1:0]         ptr;
    logic [COORD_W-1:0]       s_px, s_py, s_pw, s_ph;
    logic [NUM_OBJ*COORD_W-1:0] s_ox, s_oy, s_ow, s_oh;
    logic [NUM_OBJ-1:0]       s_valid;
    logic [COORD_W-1:0]       cx, cy, cw, ch;
    logic                     ov, hit_now, last;

    assign cx = s_ox[slot_off(int'(ptr), COORD_W) +: COORD_W];
    assign cy = s_oy[slot_off(int'(ptr), COORD_W) +: COORD_W];
    assign cw = s_ow[slot_off(int'(ptr), COORD_W) +: COORD_W];
    assign ch = s_oh[slot_off(int'(ptr), COORD_W) +: COORD_W];

    aabb_overlap #(.COORD_W(COORD_W)) u_ov (
        .ax(s_px), .ay(s_py), .aw(s_pw), .ah(s_ph),
        .bx(cx),   .by(cy),   .bw(cw),   .bh(ch),
        .overlap(ov)
    );

    assign hit_now = ov && s_valid[ptr];
    assign last    = (ptr == IDX_W'(NUM_OBJ - 1));
    assign hit_any = |hit_mask;

    always_comb begin
        hit_idx = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (hit_mask[i]) hit_idx = IDX_W'(i);
        end
    end

    // Snapshot isolates the scan from input changes.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start && !rst) begin
            s_px    <= px;
            s_py    <= py;
            s_pw    <= pw;
            s_ph    <= ph;
            s_ox    <= obj_x;
            s_oy    <= obj_y;
            s_ow    <= obj_w;
            s_oh    <= obj_h;
            s_valid <= obj_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            hit_mask <= '0;
            ptr      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        hit_mask <= '0;
                        ptr      <= '0;
                        busy     <= 1'b1;
                        state    <= en ? ST_SCAN : ST_FIN;
                    end
                end
                ST_SCAN: begin
                    if (hit_now) hit_mask[ptr] <= 1'b1;
                    ptr <= ptr + IDX_W'(1);
                    if (last || (EARLY && hit_now)) state <= ST_FIN;
                end
                ST_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_collide_scan.sv
// Directed self-checking bench for collide_scan.
// Expected values are hand-computed for NUM_OBJ=8, COORD_W=9.
module tb_collide_scan;

    localparam int CW = 9;
    localparam int NO = 8;

    logic          clk, rst, start, en;
    logic [CW-1:0] px, py, pw, ph;
    logic [NO*CW-1:0] obj_x, obj_y, obj_w, obj_h;
    logic [NO-1:0] obj_valid;
    logic          busy, done, hit_any;
    logic [NO-1:0] hit_mask;
    logic [2:0]    hit_idx;

    logic [CW-1:0] ox [NO];
    logic [CW-1:0] oy [NO];
    logic [CW-1:0] ow [NO];
    logic [CW-1:0] oh [NO];

    int total = 0;
    int bad   = 0;
    int n;
    int dcount;
    bit seen;

    collide_scan #(.COORD_W(CW), .NUM_OBJ(NO)) dut (
        .clk(clk), .rst(rst), .start(start), .en(en),
        .px(px), .py(py), .pw(pw), .ph(ph),
        .obj_x(obj_x), .obj_y(obj_y), .obj_w(obj_w), .obj_h(obj_h),
        .obj_valid(obj_valid),
        .busy(busy), .done(done), .hit_any(hit_any),
        .hit_mask(hit_mask), .hit_idx(hit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        obj_x = '0;
        obj_y = '0;
        obj_w = '0;
        obj_h = '0;
        for (int i = 0; i < NO; i++) begin
            obj_x[i*CW +: CW] = ox[i];
            obj_y[i*CW +: CW] = oy[i];
            obj_w[i*CW +: CW] = ow[i];
            obj_h[i*CW +: CW] = oh[i];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic far_all;
        for (int i = 0; i < NO; i++) begin
            ox[i] = 9'd300; oy[i] = 9'd300;
            ow[i] = 9'd4;   oh[i] = 9'd4;
        end
        obj_valid = '1;
    endtask

    task automatic set_obj(input int i, input int x, input int y,
                           input int w, input int h);
        ox[i] = CW'(x); oy[i] = CW'(y);
        ow[i] = CW'(w); oh[i] = CW'(h);
    endtask

    task automatic set_probe(input int x, input int y,
                             input int w, input int h);
        px = CW'(x); py = CW'(y); pw = CW'(w); ph = CW'(h);
    endtask

    // Issue one start and count cycles from the start edge to done.
    task automatic run_scan(output int cyc);
        cyc = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!done && cyc < 50) begin
            tick();
            cyc++;
        end
        if (!done) cyc = -1;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        en = 1'b1;
        set_probe(10, 10, 16, 16);
        far_all();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_any", 32'(hit_any), 0);
        chk("rst_mask", 32'(hit_mask), 0);
        chk("rst_idx", 32'(hit_idx), 0);

        // single hit at slot 5
        set_obj(5, 20, 20, 8, 8);
        run_scan(n);
        chk("single_lat", 32'(n), 9);
        chk("single_mask", 32'(hit_mask), 32'h20);
        chk("single_idx", 32'(hit_idx), 5);
        chk("single_any", 32'(hit_any), 1);
        chk("single_busy", 32'(busy), 0);
        tick();
        chk("single_pulse", 32'(done), 0);
        chk("single_hold", 32'(hit_mask), 32'h20);

        // reset at scan cycle 3
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_busy", 32'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_mask", 32'(hit_mask), 0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk("mid_no_done", 32'(seen), 0);

        // touching edges, invalid slot, zero width
        far_all();
        set_obj(0, 26, 10, 4, 4);
        set_obj(2, 12, 12, 4, 4);
        set_obj(4, 12, 26, 4, 4);
        set_obj(7, 15, 15, 0, 4);
        obj_valid[2] = 1'b0;
        run_scan(n);
        chk("touch_lat", 32'(n), 9);
        chk("touch_mask", 32'(hit_mask), 0);
        chk("touch_any", 32'(hit_any), 0);
        chk("touch_idx", 32'(hit_idx), 0);

        // widened sums near the top of the coordinate range
        far_all();
        set_probe(500, 0, 20, 10);
        set_obj(1, 505, 0, 5, 5);
        set_obj(3, 0, 0, 8, 8);
        run_scan(n);
        chk("ovf_mask", 32'(hit_mask), 32'h02);
        chk("ovf_idx", 32'(hit_idx), 1);
        chk("ovf_any", 32'(hit_any), 1);

        // several hits including the last slot
        far_all();
        set_probe(10, 10, 16, 16);
        set_obj(2, 12, 12, 4, 4);
        set_obj(6, 20, 20, 8, 8);
        set_obj(7, 0, 0, 11, 11);
        run_scan(n);
`ifdef COLLIDE_EARLY_EXIT_EN
        chk("multi_lat", 32'(n), 4);
        chk("multi_mask", 32'(hit_mask), 32'h04);
`else
        chk("multi_lat", 32'(n), 9);
        chk("multi_mask", 32'(hit_mask), 32'hC4);
`endif
        chk("multi_idx", 32'(hit_idx), 2);
        chk("multi_any", 32'(hit_any), 1);

        // en=0 gives an empty result after FIN
        en = 1'b0;
        run_scan(n);
        chk("en0_lat", 32'(n), 1);
        chk("en0_mask", 32'(hit_mask), 0);
        chk("en0_any", 32'(hit_any), 0);
        chk("en0_idx", 32'(hit_idx), 0);
        en = 1'b1;

        // start while busy ignored; mid-scan input changes ignored
        tick();
        far_all();
        set_obj(5, 20, 20, 8, 8);
        dcount = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        set_probe(300, 100, 4, 4);
        obj_valid = '0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done) dcount++;
            tick();
        end
        chk("busy_one_done", 32'(dcount), 1);
        chk("snap_mask", 32'(hit_mask), 32'h20);
        chk("snap_idx", 32'(hit_idx), 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
